// File: rtl/scan_defs.sv
// Shared definitions for the round-robin scan-select generator.
package scan_defs;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_BLANK = 2'd2
  } scan_state_t;

  localparam int DEF_DWELL = 4;
  localparam int DEF_BLANK = 1;

  // Bits needed to count 0..max(a,b)-1, never fewer than one.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Cyclic next-set-bit finder: first mask bit strictly after sel.
module rr_next_sel #(
  parameter int SEL_W = 1
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [(1<<SEL_W)-1:0]   mask,
  output logic [SEL_W-1:0]        nxt
);

  localparam int N = 1 << SEL_W;

  // Walk from the farthest offset down so the nearest set bit wins;
  // offset N wraps back onto sel itself.
  always_comb begin
    nxt = sel;
    for (int k = N; k >= 1; k--) begin
      if (mask[sel + SEL_W'(k)]) begin
        nxt = sel + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/scan_sel_gen.sv
// Round-robin scan-select generator: steps sel over active mask
// channels with a fixed dwell and optional blanking gap.
module scan_sel_gen
  import scan_defs::*;
#(
  parameter int SEL_W = 1,
  parameter int DWELL = DEF_DWELL,
  parameter int BLANK = DEF_BLANK
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic [(1<<SEL_W)-1:0]   mask,
  output logic [SEL_W-1:0]        sel,
  output logic                    en,
  output logic                    wrap
);

  localparam int N  = 1 << SEL_W;
  localparam int CW = cnt_w(DWELL, BLANK);

  localparam logic [CW-1:0] DLAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLAST =
    (BLANK > 0) ? CW'(BLANK - 1) : '0;
  localparam logic [SEL_W-1:0] TOP = SEL_W'(N - 1);

  scan_state_t      state;
  logic [CW-1:0]    cnt;
  logic [SEL_W-1:0] nxt;
  logic [SEL_W-1:0] first;
  logic             any;

  assign any = |mask;

  rr_next_sel #(.SEL_W(SEL_W)) u_nxt (
    .sel  (sel),
    .mask (mask),
    .nxt  (nxt)
  );

  // Searching after the top index yields the lowest set bit.
  rr_next_sel #(.SEL_W(SEL_W)) u_first (
    .sel  (TOP),
    .mask (mask),
    .nxt  (first)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sel   <= '0;
      en    <= 1'b0;
      wrap  <= 1'b0;
      cnt   <= '0;
    end else begin
      wrap <= 1'b0;
      if (!run) begin
        state <= S_IDLE;
        en    <= 1'b0;
        cnt   <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            cnt <= '0;
            if (any) begin
              state <= S_SHOW;
              sel   <= first;
              en    <= 1'b1;
            end
          end
          S_SHOW: begin
            if (cnt == DLAST) begin
              cnt <= '0;
              if (!any) begin
                state <= S_IDLE;
                en    <= 1'b0;
              end else if (BLANK == 0) begin
                state <= S_SHOW;
                sel   <= nxt;
                en    <= 1'b1;
                wrap  <= (nxt <= sel);
              end else begin
                state <= S_BLANK;
                en    <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_BLANK: begin
            if (cnt == BLAST) begin
              cnt <= '0;
              if (!any) begin
                state <= S_IDLE;
                en    <= 1'b0;
              end else begin
                state <= S_SHOW;
                sel   <= nxt;
                en    <= 1'b1;
                wrap  <= (nxt <= sel);
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            en    <= 1'b0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed bench for scan_sel_gen across three parameter sets.
module tb_scan_sel_gen;

  logic clk;
  int   total;
  int   bad;

  logic       rst_a, run_a;
  logic [1:0] mask_a;
  logic       sel_a, en_a, wrap_a;

  logic       rst_b, run_b;
  logic [3:0] mask_b;
  logic [1:0] sel_b;
  logic       en_b, wrap_b;

  logic       rst_c, run_c;
  logic [1:0] mask_c;
  logic       sel_c, en_c, wrap_c;

  scan_sel_gen #(.SEL_W(1), .DWELL(4), .BLANK(1)) dut_a (
    .clk(clk), .rst(rst_a), .run(run_a), .mask(mask_a),
    .sel(sel_a), .en(en_a), .wrap(wrap_a)
  );

  scan_sel_gen #(.SEL_W(2), .DWELL(4), .BLANK(1)) dut_b (
    .clk(clk), .rst(rst_b), .run(run_b), .mask(mask_b),
    .sel(sel_b), .en(en_b), .wrap(wrap_b)
  );

  scan_sel_gen #(.SEL_W(1), .DWELL(1), .BLANK(0)) dut_c (
    .clk(clk), .rst(rst_c), .run(run_c), .mask(mask_c),
    .sel(sel_c), .en(en_c), .wrap(wrap_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_a(input logic [1:0] m);
    @(negedge clk);
    rst_a = 1'b1; run_a = 1'b1; mask_a = m;
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_a = 1'b1; run_a = 1'b1; mask_a = 2'b11;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if ({sel_a, en_a, wrap_a} !== 3'b000) begin
        bad++;
        $display("FAIL reset c%0d sel/en/wrap=%b want 000",
                 c, {sel_a, en_a, wrap_a});
      end
    end
    rst_a = 1'b0;
    @(negedge clk);
    total++;
    if ({sel_a, en_a, wrap_a} !== 3'b010) begin
      bad++;
      $display("FAIL reset_release sel/en/wrap=%b want 010",
               {sel_a, en_a, wrap_a});
    end
  endtask

  task automatic test_basic;
    logic es, ss, ws;
    start_a(2'b11);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      es = (i % 5) != 4;
      ss = (i % 10) >= 5;
      ws = (i == 10) || (i == 20);
      total++;
      if ({sel_a, en_a, wrap_a} !== {ss, es, ws}) begin
        bad++;
        $display("FAIL basic i=%0d sel/en/wrap=%b want %b",
                 i, {sel_a, en_a, wrap_a}, {ss, es, ws});
      end
    end
  endtask

  task automatic test_skip_single;
    logic [1:0] ss;
    logic       es, ws;
    @(negedge clk);
    rst_b = 1'b1; run_b = 1'b1; mask_b = 4'b1010;
    @(negedge clk);
    rst_b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      es = (i % 5) != 4;
      if (i < 20) begin
        ss = ((i / 5) % 2 == 0) ? 2'd1 : 2'd3;
        ws = (i == 10);
      end else begin
        ss = 2'd2;
        ws = (i % 5) == 0;
      end
      total++;
      if ({sel_b, en_b, wrap_b} !== {ss, es, ws}) begin
        bad++;
        $display("FAIL skip i=%0d sel/en/wrap=%b want %b",
                 i, {sel_b, en_b, wrap_b}, {ss, es, ws});
      end
      if (i == 19) mask_b = 4'b0100;
    end
  endtask

  task automatic test_blank0;
    logic ss, ws;
    @(negedge clk);
    rst_c = 1'b1; run_c = 1'b1; mask_c = 2'b11;
    @(negedge clk);
    rst_c = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ss = (i % 2) == 1;
      ws = (i > 0) && ((i % 2) == 0);
      total++;
      if ({sel_c, en_c, wrap_c} !== {ss, 1'b1, ws}) begin
        bad++;
        $display("FAIL blank0 i=%0d sel/en/wrap=%b want %b",
                 i, {sel_c, en_c, wrap_c}, {ss, 1'b1, ws});
      end
    end
  endtask

  task automatic test_stop;
    start_a(2'b11);
    for (int i = 0; i < 7; i++) @(negedge clk);
    // now in the 2nd SHOW cycle of channel 1
    run_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({sel_a, en_a, wrap_a} !== 3'b100) begin
        bad++;
        $display("FAIL stop i=%0d sel/en/wrap=%b want 100",
                 i, {sel_a, en_a, wrap_a});
      end
    end
    run_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({sel_a, en_a, wrap_a} !== {1'b0, i != 4, 1'b0}) begin
        bad++;
        $display("FAIL restart i=%0d sel/en/wrap=%b want %b",
                 i, {sel_a, en_a, wrap_a}, {1'b0, i != 4, 1'b0});
      end
    end
  endtask

  task automatic test_mask_clear;
    logic es, ss;
    start_a(2'b11);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 5) begin
        es = (i <= 8) || (i == 11);
        ss = (i != 11);
        total++;
        if ({sel_a, en_a, wrap_a} !== {ss, es, 1'b0}) begin
          bad++;
          $display("FAIL mclr i=%0d sel/en/wrap=%b want %b",
                   i, {sel_a, en_a, wrap_a}, {ss, es, 1'b0});
        end
      end
      if (i == 5) mask_a = 2'b00;
      if (i == 10) mask_a = 2'b01;
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_a = 1'b1; run_a = 1'b0; mask_a = '0;
    rst_b = 1'b1; run_b = 1'b0; mask_b = '0;
    rst_c = 1'b1; run_c = 1'b0; mask_c = '0;
    test_reset;
    test_basic;
    test_skip_single;
    test_blank0;
    test_stop;
    test_mask_clear;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
